// File: rtl/branch_predictor_bimodal.sv
// Bimodal branch predictor: a PC-indexed table of 2-bit saturating counters,
// swept to weak-not-taken after reset, with resolved/correct branch statistics.
module branch_predictor_bimodal #(
  parameter int ENTRY = 1024,
  parameter int IDX_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_pred,
  output logic        ready,
  output logic [31:0] branch_count,
  output logic [31:0] correct_count
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY - 1);

  state_t           state, state_d;
  logic [IDX_W-1:0] init_addr;
  logic [1:0]       ram [ENTRY];
  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic             unused_pc_bits;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

  // Word-aligned PCs: drop the byte offset, keep IDX_W bits; upper bits alias.
  assign pred_idx = pred_pc[IDX_W+1:2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                            upd_pc[31:IDX_W+2], upd_pc[1:0]};

  // Read-before-write: the lookup sees the stored value, updates land next edge.
  assign pred_taken = ready & ~rst & ram[pred_idx][1];

  always_comb begin
    state_d = state;
    case (state)
      INIT:    if (init_addr == LAST_IDX) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      init_addr     <= '0;
      ready         <= 1'b0;
      branch_count  <= '0;
      correct_count <= '0;
    end else begin
      state <= state_d;
      ready <= (state_d == RUN);
      if (state == INIT) init_addr <= init_addr + IDX_W'(1);
      if (state == RUN && upd_valid) begin
        branch_count <= sat_inc(branch_count);
        if (upd_taken == upd_pred) correct_count <= sat_inc(correct_count);
      end
    end
  end

  // Table contents survive reset; only the INIT sweep rewrites them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)
        ram[init_addr] <= 2'b01;
      else if (upd_valid)
        ram[upd_idx] <= ctr_next(ram[upd_idx], upd_taken);
    end
  end

endmodule

// File: tb/tb_branch_predictor_bimodal.sv
// Directed bench for branch_predictor_bimodal: init sweep timing, counter
// saturation, read-before-write, aliasing, INIT update masking and mid-run reset.
module tb_branch_predictor_bimodal;

  logic        clk;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred;
  logic        ready;
  logic [31:0] branch_count;
  logic [31:0] correct_count;

  int checks   = 0;
  int failures = 0;

  branch_predictor_bimodal #(.ENTRY(1024), .IDX_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_pred      (upd_pred),
    .ready         (ready),
    .branch_count  (branch_count),
    .correct_count (correct_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Counts cycles until ready rises; optionally pulses upd_valid at cycle 500.
  task automatic wait_ready(input bit pulse, output int n);
    n = 0;
    while (ready !== 1'b1 && n < 1100) begin
      @(posedge clk); #1;
      n++;
      upd_valid = (pulse && n == 500);
    end
    upd_valid = 1'b0;
  endtask

  task automatic count_bad_entries(output int bad);
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (dut.ram[i] !== 2'b01) bad++;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic pred);
    upd_pc    = pc;
    upd_taken = taken;
    upd_pred  = pred;
    upd_valid = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  int n;
  int bad;

  initial begin
    rst = 1'b1; pred_pc = '0; upd_valid = 1'b0;
    upd_pc = '0; upd_taken = 1'b0; upd_pred = 1'b0;

    // Reset then idle
    @(posedge clk); #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_branch", branch_count, 32'd0);
    check("rst_correct", correct_count, 32'd0);
    check("rst_pred", {31'd0, pred_taken}, 32'd0);
    rst = 1'b0;
    wait_ready(1'b0, n);
    check("init_cycles", n, 32'd1024);
    count_bad_entries(bad);
    check("init_entries", bad, 32'd0);
    pred_pc = 32'h0001_0040; #1;
    check("init_pred", {31'd0, pred_taken}, 32'd0);

    // Repeated taken updates saturate at strong-taken
    update(32'h0001_0040, 1'b1, 1'b0);
    check("e16_upd1", {30'd0, dut.ram[16]}, 32'd2);
    check("pred_after_upd1", {31'd0, pred_taken}, 32'd1);
    update(32'h0001_0040, 1'b1, 1'b0);
    check("e16_upd2", {30'd0, dut.ram[16]}, 32'd3);
    update(32'h0001_0040, 1'b1, 1'b0);
    update(32'h0001_0040, 1'b1, 1'b0);
    check("e16_sat_hi", {30'd0, dut.ram[16]}, 32'd3);
    check("branch_4", branch_count, 32'd4);
    check("correct_0", correct_count, 32'd0);

    // Back to weak-NT, then same-index lookup and update in one cycle
    update(32'h0001_0040, 1'b0, 1'b0);
    update(32'h0001_0040, 1'b0, 1'b0);
    check("e16_back_01", {30'd0, dut.ram[16]}, 32'd1);
    pred_pc   = 32'h0000_0040;
    upd_pc    = 32'h0000_0040;
    upd_taken = 1'b1;
    upd_pred  = 1'b1;
    upd_valid = 1'b1;
    #1;
    check("rbw_same_cycle", {31'd0, pred_taken}, 32'd0);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    check("rbw_next_cycle", {31'd0, pred_taken}, 32'd1);
    check("branch_7", branch_count, 32'd7);
    check("correct_3", correct_count, 32'd3);

    // Mid-RUN reset, with an update pulse at INIT cycle 500
    rst = 1'b1; #1;
    check("pred_in_rst", {31'd0, pred_taken}, 32'd0);
    @(posedge clk); #1;
    check("rst2_ready", {31'd0, ready}, 32'd0);
    check("rst2_branch", branch_count, 32'd0);
    check("rst2_correct", correct_count, 32'd0);
    rst = 1'b0;
    upd_pc = 32'h0001_0040; upd_taken = 1'b1; upd_pred = 1'b1;
    wait_ready(1'b1, n);
    check("rst2_cycles", n, 32'd1024);
    count_bad_entries(bad);
    check("rst2_entries", bad, 32'd0);
    check("init_upd_branch", branch_count, 32'd0);
    check("init_upd_correct", correct_count, 32'd0);

    // Aliasing: 0x1004 and 0x0004 share entry 1
    update(32'h0000_1004, 1'b1, 1'b1);
    update(32'h0000_1004, 1'b1, 1'b1);
    check("alias_entry1", {30'd0, dut.ram[1]}, 32'd3);
    pred_pc = 32'h0000_0004; #1;
    check("alias_pred", {31'd0, pred_taken}, 32'd1);

    // Not-taken updates saturate at strong-NT
    update(32'h0000_0008, 1'b0, 1'b1);
    check("e2_dec1", {30'd0, dut.ram[2]}, 32'd0);
    update(32'h0000_0008, 1'b0, 1'b1);
    check("e2_sat_lo", {30'd0, dut.ram[2]}, 32'd0);
    pred_pc = 32'h0000_0008; #1;
    check("e2_pred", {31'd0, pred_taken}, 32'd0);
    check("branch_4b", branch_count, 32'd4);
    check("correct_2", correct_count, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
